seq_detector: RTL and testbench

- Serial pattern detector placed directly downstream of the registered D flip-flop stage.
- Consumes the registered bit stream, one qualified bit per clock, and matches it against a parameterised pattern.
- Emits a one-cycle registered DETECT pulse for each match and keeps a saturating match count.
- Supports overlapping and non-overlapping matching.

---
 rtl/seq_detector.sv | 117 +++++++++++
 tb/tb_seq_detector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detector.sv
// ============================================================================
// seq_detector
// ----------------------------------------------------------------------------
// Serial pattern detector that sits directly behind a registered D flip-flop
// stage. Each cycle with DIN_VALID high, one bit is shifted into a history
// register and compared against PATTERN (MSB = first bit received). A match
// produces a one-cycle registered DETECT pulse and bumps a saturating counter.
//
// Matching modes (OVERLAP):
//   1 : the tail of one match may serve as the head of the next.
//   0 : after a match, PAT_LEN fresh bits must arrive before the next match.
//
// Ports:
//   CLK        in   1      rising-edge clock
//   RST        in   1      asynchronous, active-high reset
//   DIN        in   1      serial data bit (upstream flip-flop Q)
//   DIN_VALID  in   1      qualifies DIN for this cycle
//   CLR        in   1      synchronous clear of history, fill and count
//   DETECT     out  1      registered one-cycle pulse per match
//   COUNT      out  CNT_W  saturating number of matches
//
// Every output comes straight from a flop; no input reaches an output
// combinationally.
// ============================================================================
module seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DIN,
    input  logic             DIN_VALID,
    input  logic             CLR,
    output logic             DETECT,
    output logic [CNT_W-1:0] COUNT
);

    // fill must represent 0..PAT_LEN inclusive.
    localparam int                FILL_W   = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
    // A match is only allowed once PAT_LEN-1 real bits are already held, so
    // together with the incoming bit the whole window consists of real data.
    // This keeps the zero-filled history from matching (even PATTERN == 0).
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};

    logic [PAT_LEN-1:0] hist_q,   hist_d;
    logic [FILL_W-1:0]  fill_q,   fill_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               detect_q, detect_d;

    logic [PAT_LEN-1:0] next_hist;
    logic               match;

    // Candidate window if the current bit were accepted.
    assign next_hist = {hist_q[PAT_LEN-2:0], DIN};
    assign match     = (next_hist == PATTERN) && (fill_q >= FILL_ARM);

    // ------------------------------------------------------------------------
    // Next-state logic. Priority: CLR > DIN_VALID > hold.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        hist_d   = hist_q;
        fill_d   = fill_q;
        count_d  = count_q;
        detect_d = 1'b0;

        if (CLR) begin
            // DIN is ignored in a clear cycle even when qualified.
            hist_d  = '0;
            fill_d  = '0;
            count_d = '0;
        end else if (DIN_VALID) begin
            hist_d = next_hist;
            if (match) begin
                detect_d = 1'b1;
                if (count_q != CNT_SAT) begin
                    count_d = count_q + 1'b1;
                end
                // Non-overlap: history is kept but disarmed until PAT_LEN
                // new bits have been seen.
                fill_d = OVERLAP ? FILL_MAX : '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
        // Gap cycles (DIN_VALID=0) hold history, fill and count, so a
        // partial match survives any number of idle cycles.
    end

    // ------------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist_q   <= '0;
            fill_q   <= '0;
            count_q  <= '0;
            detect_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            count_q  <= count_d;
            detect_q <= detect_d;
        end
    end

    assign DETECT = detect_q;
    assign COUNT  = count_q;

endmodule

// File: tb/tb_seq_detector.sv
// ============================================================================
// tb_seq_detector
// ----------------------------------------------------------------------------
// Three detector instances share one clock and reset:
//   u0 : PATTERN=1011, OVERLAP=1, CNT_W=8
//   u1 : PATTERN=1011, OVERLAP=0, CNT_W=8
//   u2 : PATTERN=1011, OVERLAP=1, CNT_W=2 (saturation)
// Stimulus drives one instance per cycle (the others idle with
// DIN_VALID=0) and pushes the hand-computed post-edge DETECT/COUNT of the
// driven instance into a queue. A monitor pops one entry after each rising
// edge and compares it with that instance's outputs.
// ============================================================================
module tb_seq_detector;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [2:0] din, vld, clr;
    logic [2:0] det;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int    dut;
        bit    det;
        int    cnt;
        string name;
    } exp_t;

    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u0 (
        .CLK(CLK), .RST(RST), .DIN(din[0]), .DIN_VALID(vld[0]), .CLR(clr[0]),
        .DETECT(det[0]), .COUNT(cnt0)
    );

    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u1 (
        .CLK(CLK), .RST(RST), .DIN(din[1]), .DIN_VALID(vld[1]), .CLR(clr[1]),
        .DETECT(det[1]), .COUNT(cnt1)
    );

    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u2 (
        .CLK(CLK), .RST(RST), .DIN(din[2]), .DIN_VALID(vld[2]), .CLR(clr[2]),
        .DETECT(det[2]), .COUNT(cnt2)
    );

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int count_of(input int dut);
        case (dut)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    // Monitor: one expected entry per rising edge, checked just after it.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, ".det"}, int'(det[e.dut]), int'(e.det));
            check({e.name, ".cnt"}, count_of(e.dut), e.cnt);
        end
    end

    // One cycle of stimulus on instance `dut`, with the expected outputs
    // after the next rising edge.
    task automatic step(input int dut, input bit d, input bit v, input bit c,
                        input bit e_det, input int e_cnt, input string name);
        @(negedge CLK);
        din = '0;
        vld = '0;
        clr = '0;
        din[dut] = d;
        vld[dut] = v;
        clr[dut] = c;
        exp_q.push_back('{dut, e_det, e_cnt, name});
    endtask

    // Back-to-back valid bits; vectors are listed first-bit-first (MSB),
    // counts as one hex nibble per bit.
    task automatic run(input int dut, input int n, input logic [31:0] bits,
                       input logic [31:0] dets, input logic [63:0] cnts,
                       input string name);
        for (int i = 0; i < n; i++) begin
            step(dut, bits[n-1-i], 1'b1, 1'b0, dets[n-1-i],
                 int'(cnts[(n-1-i)*4 +: 4]), $sformatf("%s[%0d]", name, i));
        end
    endtask

    // Idle the inputs and make sure every expectation has been consumed.
    task automatic drain();
        @(negedge CLK);
        din = '0;
        vld = '0;
        clr = '0;
        @(posedge CLK);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_all_reset(input string name);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.det%0d", name, i), int'(det[i]), 0);
            check($sformatf("%s.cnt%0d", name, i), count_of(i), 0);
        end
    endtask

    initial begin
        din = '0;
        vld = '0;
        clr = '0;

        // Power-on reset.
        #1 RST = 1'b1;
        #2 check_all_reset("por");
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Overlap: matches on bits 4 and 7.
        run(0, 7, 32'b1011011, 32'b0001001, 64'h0001112, "ovl");
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 2, "ovl_idle");

        // Non-overlap: tail reuse is rejected.
        run(1, 7, 32'b1011011, 32'b0001000, 64'h0001111, "novl_a");
        step(1, 1'b0, 1'b0, 1'b1, 1'b0, 0, "novl_clr");
        // Non-overlap: second match once four fresh bits are in.
        run(1, 8, 32'b10111011, 32'b00010001, 64'h00011112, "novl_b");

        // Valid gaps: 3 idle cycles between bits, single DETECT at the end.
        step(0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "gap_clr");
        begin
            logic [3:0] gbits;
            gbits = 4'b1011;
            for (int i = 0; i < 4; i++) begin
                step(0, gbits[3-i], 1'b1, 1'b0, (i == 3), (i == 3) ? 1 : 0,
                     $sformatf("gap_bit%0d", i));
                if (i < 3) begin
                    for (int g = 0; g < 3; g++) begin
                        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 0,
                             $sformatf("gap%0d_%0d", i, g));
                    end
                end
            end
        end
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "gap_after");

        // CLR with a qualified 1 on DIN: history discarded, DIN ignored.
        run(0, 3, 32'b101, 32'b000, 64'h111, "clr_pre");
        step(0, 1'b1, 1'b1, 1'b1, 1'b0, 0, "clr_cyc");
        run(0, 1, 32'b1, 32'b0, 64'h0, "clr_post");
        run(0, 4, 32'b1011, 32'b0001, 64'h0001, "clr_fresh");

        // Saturation at 3 with CNT_W=2; DETECT keeps pulsing.
        run(2, 16, 32'b1011011011011011, 32'b0001001001001001,
            64'h0001112223333333, "sat");

        // Async reset mid-cycle with partial 1,0,1 loaded.
        run(0, 3, 32'b101, 32'b000, 64'h111, "rst_pre");
        drain();
        #1 RST = 1'b1;
        #1 check_all_reset("rst_async");
        repeat (3) @(negedge CLK);
        check_all_reset("rst_hold");
        RST = 1'b0;
        // The pre-reset partial must be gone: 1,1 never matches, and a full
        // pattern needs four real bits.
        run(0, 5, 32'b11011, 32'b00001, 64'h00001, "rst_post");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
